// File: rtl/key_bus_pkg.sv
// Shared definitions for the security-key bus: address window, code field,
// state encodings and the responder's 6-bit XOR sequence generator.
package key_bus_pkg;

  localparam int         BA_W     = 14;
  localparam int         CODE_LSB = 4;      // code lives in ba[7:4]
  localparam logic [1:0] BA_WIN   = 2'b01;  // ba[13]=0, ba[12]=1

  typedef enum logic [1:0] {KS_IDLE, KS_REQ, KS_RUN, KS_FINISH} key_state_e;
  typedef enum logic [1:0] {CY_IDLE, CY_SETUP, CY_STROBE, CY_HOLD} cyc_state_e;

  function automatic logic key_model_bit(input logic [5:0] s);
    return s[0] ^ s[3] ^ s[5];
  endfunction

  function automatic logic [5:0] key_model_next(input logic [5:0] s);
    return {s[4:0], key_model_bit(s)};
  endfunction

  function automatic logic [BA_W-1:0] key_bus_addr(input logic [3:0] code);
    logic [BA_W-1:0] a;
    a                  = '0;
    a[13:12]           = BA_WIN;
    a[CODE_LSB +: 4]   = code;
    return a;
  endfunction

endpackage

// File: rtl/key_bus_cycle.sv
// One strobed bus cycle: SETUP (1 clk), STROBE (STB_CLKS clks), HOLD (1 clk).
// A request seen in HOLD chains the next cycle with no idle gap.
module key_bus_cycle
  import key_bus_pkg::*;
#(
  parameter int STB_CLKS = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_i,
  input  logic [3:0]      code_i,
  input  logic            rd_i,
  input  logic            sdrd_i,
  output logic            ack_o,
  output logic            sample_en_o,
  output logic            sample_o,
  output logic [BA_W-1:0] ba_o,
  output logic            br_w_o,
  output logic            sser_n_o
);

  cyc_state_e      state_q;
  logic [3:0]      cnt_q;
  logic            rd_q;
  logic [BA_W-1:0] ba_q;
  logic            brw_q;
  logic            sser_n_q;
  logic            last_stb;

  assign last_stb    = (cnt_q == 4'(STB_CLKS - 1));
  assign ack_o       = (state_q == CY_HOLD);
  assign sample_en_o = (state_q == CY_STROBE) && last_stb && rd_q;
  assign sample_o    = sdrd_i;
  assign ba_o        = ba_q;
  assign br_w_o      = brw_q;
  assign sser_n_o    = sser_n_q;

  // Cycle timing FSM; bus outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= CY_IDLE;
      cnt_q    <= '0;
      rd_q     <= 1'b0;
      ba_q     <= '0;
      brw_q    <= 1'b0;
      sser_n_q <= 1'b1;
    end else begin
      case (state_q)
        CY_IDLE, CY_HOLD: begin
          if (req_i) begin
            state_q  <= CY_SETUP;
            ba_q     <= key_bus_addr(code_i);
            brw_q    <= 1'b1;
            sser_n_q <= 1'b1;
            rd_q     <= rd_i;
          end else begin
            state_q  <= CY_IDLE;
            ba_q     <= '0;
            brw_q    <= 1'b0;
            sser_n_q <= 1'b1;
            rd_q     <= 1'b0;
          end
        end
        CY_SETUP: begin
          state_q  <= CY_STROBE;
          sser_n_q <= 1'b0;
          cnt_q    <= '0;
        end
        CY_STROBE: begin
          if (last_stb) begin
            state_q  <= CY_HOLD;
            sser_n_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        default: state_q <= CY_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/key_challenge_initiator.sv
// Host-side challenge initiator: wins the bus, sends four unlock cycles, then
// NREAD read cycles whose sampled bits are checked against the local model.
module key_challenge_initiator
  import key_bus_pkg::*;
#(
  parameter logic [15:0] UNLOCK_SEQ  = 16'h28A9,
  parameter logic [3:0]  READ_CODE   = 4'h0,
  parameter int          NREAD       = 16,
  parameter logic [5:0]  SEED        = 6'h2D,
  parameter int          STB_CLKS    = 2,
  parameter int          GNT_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             bus_req,
  input  logic             bus_gnt,
  output logic [13:0]      ba,
  output logic             br_w,
  output logic             sser_n,
  input  logic             sdrd,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [NREAD-1:0] resp
);

  localparam int NSTEP = 4 + NREAD;
  localparam int TO_W  = (GNT_TIMEOUT > 1) ? $clog2(GNT_TIMEOUT + 1) : 1;

  key_state_e       state_q;
  logic [5:0]       step_q;
  logic [TO_W-1:0]  to_cnt_q;
  logic [5:0]       s_q;
  logic             err_q, busy_q, done_q, pass_q, timeout_q, bus_req_q;
  logic [NREAD-1:0] resp_q;
  logic [NREAD:0]   resp_sh;

  logic [5:0] step_nxt, code_step;
  logic       more, cyc_req, cyc_rd, cyc_ack, smp_en, smp;
  logic [3:0] cyc_code;

  // Next cycle selection: in RUN the code is prepared for the step after HOLD.
  always_comb begin
    step_nxt  = step_q + 6'd1;
    more      = (step_nxt < 6'(NSTEP));
    code_step = (state_q == KS_RUN) ? step_nxt : step_q;
    cyc_rd    = (code_step >= 6'd4);
    case (code_step[1:0])
      2'd0:    cyc_code = UNLOCK_SEQ[15:12];
      2'd1:    cyc_code = UNLOCK_SEQ[11:8];
      2'd2:    cyc_code = UNLOCK_SEQ[7:4];
      default: cyc_code = UNLOCK_SEQ[3:0];
    endcase
    if (cyc_rd) cyc_code = READ_CODE;
    cyc_req = ((state_q == KS_REQ) && bus_gnt) ||
              ((state_q == KS_RUN) && cyc_ack && more && bus_gnt);
  end

  assign resp_sh = {resp_q, smp};

  key_bus_cycle #(.STB_CLKS(STB_CLKS)) u_cyc (
    .clk         (clk),
    .rst         (rst),
    .req_i       (cyc_req),
    .code_i      (cyc_code),
    .rd_i        (cyc_rd),
    .sdrd_i      (sdrd),
    .ack_o       (cyc_ack),
    .sample_en_o (smp_en),
    .sample_o    (smp),
    .ba_o        (ba),
    .br_w_o      (br_w),
    .sser_n_o    (sser_n)
  );

  // Step sequencer, grant watchdog, response shift and model compare.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= KS_IDLE;
      step_q    <= '0;
      to_cnt_q  <= '0;
      s_q       <= SEED;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
      bus_req_q <= 1'b0;
      resp_q    <= '0;
    end else begin
      done_q <= 1'b0;
      if (smp_en) begin
        resp_q <= resp_sh[NREAD-1:0];
        s_q    <= key_model_next(s_q);
        if (smp != key_model_bit(s_q)) err_q <= 1'b1;
      end
      case (state_q)
        KS_IDLE: begin
          if (start) begin
            state_q   <= KS_REQ;
            busy_q    <= 1'b1;
            bus_req_q <= 1'b1;
            timeout_q <= 1'b0;
            pass_q    <= 1'b0;
            s_q       <= SEED;
            resp_q    <= '0;
            err_q     <= 1'b0;
            step_q    <= '0;
            to_cnt_q  <= '0;
          end
        end
        KS_REQ: begin
          if (bus_gnt) begin
            state_q <= KS_RUN;
          end else if (to_cnt_q == TO_W'(GNT_TIMEOUT - 1)) begin
            state_q   <= KS_IDLE;
            timeout_q <= 1'b1;
            pass_q    <= 1'b0;
            done_q    <= 1'b1;
            bus_req_q <= 1'b0;
            busy_q    <= 1'b0;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        KS_RUN: begin
          // Grant loss is only acted on at the end of a cycle.
          if (cyc_ack) begin
            step_q <= step_nxt;
            if (!more) begin
              state_q <= KS_FINISH;
            end else if (!bus_gnt) begin
              state_q  <= KS_REQ;
              to_cnt_q <= '0;
            end
          end
        end
        default: begin
          state_q   <= KS_IDLE;
          bus_req_q <= 1'b0;
          pass_q    <= ~err_q;
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus_req = bus_req_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign timeout = timeout_q;
  assign resp    = resp_q;

endmodule

// File: tb/tb_key_challenge_initiator.sv
// Bench for key_challenge_initiator: behavioural responder, scoreboard of
// expected cycle codes and response words, table of challenge scenarios.
module tb_key_challenge_initiator;

  localparam int         NREAD = 16;
  localparam int         STB   = 2;
  localparam logic [5:0] SEED  = 6'h2D;
  localparam logic [3:0] RDC   = 4'h0;

  logic        clk, rst, start, bus_gnt, sdrd;
  logic        bus_req, br_w, sser_n, busy, done, pass, timeout;
  logic [13:0] ba;
  logic [NREAD-1:0] resp;

  key_challenge_initiator dut (
    .clk(clk), .rst(rst), .start(start), .bus_req(bus_req), .bus_gnt(bus_gnt),
    .ba(ba), .br_w(br_w), .sser_n(sser_n), .sdrd(sdrd), .busy(busy),
    .done(done), .pass(pass), .timeout(timeout), .resp(resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // responder / monitor state
  logic [5:0]       r_s;
  int               sidx, flip_idx, low_cnt;
  bit               prev_low, mon_en;
  logic [13:0]      ba_lat;
  logic             brw_lat;
  logic [3:0]       exp_q[$];
  logic [NREAD-1:0] resp_q[$];

  typedef struct {
    int flip;       // read index to corrupt, -1 for none
    int mode;       // 0 plain, 1 restart while busy, 2 grant drop
    bit exp_pass;
    bit chk_lat;
  } row_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic resp_bit();
    logic b;
    b = r_s[0] ^ r_s[3] ^ r_s[5];
    if (sidx >= 4 && (sidx - 4) == flip_idx) b = ~b;
    return b;
  endfunction

  task automatic strobe_end();
    logic [3:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL extra_cycle: got code %0h expected no cycle", ba_lat[7:4]);
    end else begin
      e = exp_q.pop_front();
      chk("addr", ba_lat, {2'b01, 4'b0000, e, 4'b0000});
      chk("strobe_len", low_cnt, STB);
      chk("br_w", brw_lat, 1);
    end
    if (sidx >= 4) r_s = {r_s[4:0], r_s[0] ^ r_s[3] ^ r_s[5]};
    sidx++;
  endtask

  // Advance one clock; the responder and bus monitor run at every falling edge.
  task automatic tick();
    @(negedge clk);
    if (!sser_n) begin
      low_cnt++;
      ba_lat  = ba;
      brw_lat = br_w;
    end else begin
      if (prev_low && mon_en) strobe_end();
      low_cnt = 0;
    end
    prev_low = !sser_n;
    sdrd = resp_bit();
  endtask

  task automatic prepare(input int flip);
    logic [5:0]       s;
    logic [NREAD-1:0] er;
    logic [3:0]       unl [4];
    logic             b;
    unl = '{4'h2, 4'h8, 4'hA, 4'h9};
    flip_idx = flip; r_s = SEED; sidx = 0; prev_low = 0; low_cnt = 0;
    for (int k = 0; k < 4; k++) exp_q.push_back(unl[k]);
    for (int k = 0; k < NREAD; k++) exp_q.push_back(RDC);
    s = SEED; er = '0;
    for (int i = 0; i < NREAD; i++) begin
      b  = s[0] ^ s[3] ^ s[5];
      er = {er[NREAD-2:0], (i == flip) ? ~b : b};
      s  = {s[4:0], s[0] ^ s[3] ^ s[5]};
    end
    resp_q.push_back(er);
    sdrd = resp_bit();
  endtask

  task automatic kick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Called one falling edge after the start edge.
  task automatic wait_done(input int mode, input bit exp_pass, input bit chk_lat);
    int lat = 0, stall = 0;
    bit dropped = 0, regr = 0;
    logic [NREAD-1:0] er;
    while (!done && lat < 3000) begin
      if (mode == 2) begin
        if (!dropped && sidx == 1 && !sser_n) begin
          bus_gnt = 1'b0;
          dropped = 1;
        end else if (dropped && !regr) begin
          stall++;
          if (stall == 12) begin
            chk("stall_sser_n", sser_n, 1);
            chk("stall_bus_req", bus_req, 1);
            chk("stall_cycles", sidx, 2);
            bus_gnt = 1'b1;
            regr = 1;
          end
        end
      end
      if (mode == 1 && (lat == 10 || lat == 40)) start = 1'b1;
      tick();
      start = 1'b0;
      lat++;
    end
    chk("done_seen", done, 1);
    if (chk_lat) chk("latency", lat, 1 + 1 + (4 + NREAD) * (STB + 2));
    if (resp_q.size() != 0) begin
      er = resp_q.pop_front();
      chk("resp", resp, er);
    end
    chk("pass", pass, exp_pass);
    chk("busy_end", busy, 0);
    chk("bus_req_end", bus_req, 0);
    tick();
    chk("done_pulse", done, 0);
    chk("ba_idle", {br_w, ba}, 0);
    chk("codes_left", exp_q.size(), 0);
  endtask

  row_t rows [5];

  initial begin
    int n;
    rows[0] = '{flip: -1, mode: 0, exp_pass: 1, chk_lat: 1};
    rows[1] = '{flip:  4, mode: 0, exp_pass: 0, chk_lat: 1};
    rows[2] = '{flip: -1, mode: 1, exp_pass: 1, chk_lat: 1};
    rows[3] = '{flip: 15, mode: 0, exp_pass: 0, chk_lat: 1};
    rows[4] = '{flip: -1, mode: 2, exp_pass: 1, chk_lat: 0};

    rst = 1; start = 0; bus_gnt = 1; sdrd = 0; mon_en = 1;
    r_s = SEED; sidx = 0; flip_idx = -1; prev_low = 0; low_cnt = 0;
    repeat (3) tick();
    chk("rst_outs", {bus_req, busy, done, pass, timeout, br_w}, 0);
    chk("rst_sser_n", sser_n, 1);
    chk("rst_ba", ba, 0);
    chk("rst_resp", resp, 0);
    rst = 0;
    tick();

    // start coincident with reset is dropped
    rst = 1; start = 1;
    tick();
    rst = 0; start = 0;
    tick(); tick();
    chk("start_in_rst_busy", busy, 0);
    chk("start_in_rst_req", bus_req, 0);

    foreach (rows[i]) begin
      prepare(rows[i].flip);
      kick();
      wait_done(rows[i].mode, rows[i].exp_pass, rows[i].chk_lat);
      tick();
    end

    // grant never arrives
    bus_gnt = 0;
    kick();
    n = 0;
    for (int g = 0; g < 1000 && !done; g++) begin
      if (bus_req) n++;
      tick();
    end
    chk("to_req_clks", n, 255);
    chk("to_done", done, 1);
    chk("to_flag", timeout, 1);
    chk("to_pass", pass, 0);
    chk("to_bus_req", bus_req, 0);
    tick();
    chk("to_sticky", timeout, 1);
    bus_gnt = 1;
    prepare(-1);
    kick();
    chk("to_cleared", timeout, 0);
    wait_done(0, 1, 1);

    // reset in the middle of a read strobe
    prepare(-1);
    kick();
    n = 0;
    while (!(sidx == 6 && !sser_n) && n < 500) begin
      tick();
      n++;
    end
    chk("reach_read", sidx, 6);
    mon_en = 0;
    rst = 1;
    tick();
    chk("mrst_sser_n", sser_n, 1);
    chk("mrst_bus_req", bus_req, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_resp", resp, 0);
    rst = 0;
    exp_q.delete();
    resp_q.delete();
    tick();
    prev_low = 0; low_cnt = 0; mon_en = 1;
    prepare(-1);
    kick();
    wait_done(0, 1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
